score_regfile_writer: RTL and testbench

Write side of the output-score register file read by the argmax stage. Accumulates signed output-neuron partial products streamed from the M2 output layer, commits each completed score into a 10 x 32-bit register file, and asserts `M2done` once all scores are stored. The argmax stage then reads the file through the asynchronous `raddr`/`regf_data` port.

---
 rtl/score_regfile_writer.sv | 127 ++++++++++++
 tb/tb_score_regfile_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/score_regfile_writer.sv
// score_regfile_writer: write side of the output-score register file.
// Accumulates signed partial products per output neuron, commits each
// finished score into a NUM_OUT x DATA_W register file and raises M2done
// once every score is stored. The argmax stage reads through raddr.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               pulse: restart from score 0 (aborts a run)
//   prod_valid/ready    product handshake (ready only while accumulating)
//   prod_data           signed partial product
//   prod_last           marks the final product of the current score
//   raddr / regf_data   combinational read port, 0 beyond NUM_OUT-1
//   wptr                index of the score currently accumulating
//   M2done              level, high once all scores are committed
module score_regfile_writer #(
    parameter int DATA_W  = 32,
    parameter int NUM_OUT = 10,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              prod_valid,
    input  logic [DATA_W-1:0] prod_data,
    input  logic              prod_last,
    output logic              prod_ready,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] regf_data,
    output logic [ADDR_W-1:0] wptr,
    output logic              M2done
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] sum_d;
    logic [ADDR_W-1:0] wptr_q;
    logic              ready_q;
    logic              done_q;
    logic [DATA_W-1:0] mem_q [NUM_OUT];

    logic accept;
    logic commit;
    logic last_slot;

    // Wrapping add: no saturation, modulo 2^DATA_W.
    assign sum_d = acc_q + prod_data;

    // start wins over any product presented in the same cycle.
    assign accept    = prod_valid & ready_q & ~start;
    assign commit    = accept & prod_last;
    assign last_slot = (wptr_q == ADDR_W'(NUM_OUT - 1));

    assign prod_ready = ready_q;
    assign wptr       = wptr_q;
    assign M2done     = done_q;

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            wptr_q  <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (start) begin
            state_q <= ACC;
            acc_q   <= '0;
            wptr_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        if (prod_last) begin
                            acc_q <= '0;
                            if (last_slot) begin
                                state_q <= DONE;
                                wptr_q  <= '0;
                                ready_q <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                wptr_q <= wptr_q + 1'b1;
                            end
                        end else begin
                            acc_q <= sum_d;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Register file: cleared only by rst, written on commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (commit && (wptr_q == ADDR_W'(i))) begin
                    mem_q[i] <= sum_d;
                end
            end
        end
    end

    // Read mux; addresses without an entry read as zero.
    always_comb begin
        regf_data = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (raddr == ADDR_W'(i)) begin
                regf_data = mem_q[i];
            end
        end
    end

endmodule

// File: tb/tb_score_regfile_writer.sv
// tb_score_regfile_writer: directed self-checking bench for
// score_regfile_writer (fill, wrap, gaps, abort, DONE hold, async reset).
module tb_score_regfile_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        prod_valid;
    logic [31:0] prod_data;
    logic        prod_last;
    logic        prod_ready;
    logic [3:0]  raddr;
    logic [31:0] regf_data;
    logic [3:0]  wptr;
    logic        M2done;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] vals [10];
    logic [31:0] nv   [4];
    logic [31:0] rv   [10];

    score_regfile_writer #(
        .DATA_W (32),
        .NUM_OUT(10),
        .ADDR_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .prod_valid(prod_valid),
        .prod_data (prod_data),
        .prod_last (prod_last),
        .prod_ready(prod_ready),
        .raddr     (raddr),
        .regf_data (regf_data),
        .wptr      (wptr),
        .M2done    (M2done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Advance one rising edge; return 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        prod_valid = 1'b1;
        prod_data  = d;
        prod_last  = last;
        cyc();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic rd(input string tag, input int a, input logic [31:0] exp);
        raddr = 4'(a);
        #1;
        check(tag, regf_data, exp);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        prod_valid = 1'b0;
        prod_data  = '0;
        prod_last  = 1'b0;
        raddr      = '0;
        for (int k = 0; k < 10; k++) begin
            vals[k] = 32'h1000_0000 + 32'(k * 17);
            rv[k]   = 32'hA000_0000 + 32'(k);
        end
        nv[0] = 32'h0000_0055;
        nv[1] = 32'hFFFF_FF00;
        nv[2] = 32'h1234_5678;
        nv[3] = 32'h8000_0001;

        // Reset state
        #12;
        check("rst_M2done", 32'(M2done), 32'd0);
        check("rst_ready", 32'(prod_ready), 32'd0);
        check("rst_wptr", 32'(wptr), 32'd0);
        rd("rst_rd0", 0, 32'd0);
        rst = 1'b0;
        cyc();
        check("idle_ready", 32'(prod_ready), 32'd0);

        // Basic fill: k, 2k, -1 -> 3k-1
        pulse_start();
        check("start_ready", 32'(prod_ready), 32'd1);
        for (int k = 0; k < 10; k++) begin
            send(32'(k), 1'b0);
            send(32'(2 * k), 1'b0);
            if (k == 9) check("fill_pre_done", 32'(M2done), 32'd0);
            send(32'hFFFF_FFFF, 1'b1);
        end
        check("fill_done", 32'(M2done), 32'd1);
        check("fill_ready", 32'(prod_ready), 32'd0);
        check("fill_wptr", 32'(wptr), 32'd0);
        for (int k = 0; k < 10; k++) rd("fill_mem", k, 32'(3 * k - 1));

        // DONE hold: products ignored for 20 cycles
        prod_valid = 1'b1;
        prod_data  = 32'h0BAD_F00D;
        prod_last  = 1'b1;
        repeat (20) cyc();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        check("hold_done", 32'(M2done), 32'd1);
        for (int k = 0; k < 10; k++) rd("hold_mem", k, 32'(3 * k - 1));
        pulse_start();
        check("restart_done", 32'(M2done), 32'd0);
        check("restart_ready", 32'(prod_ready), 32'd1);

        // Async reset mid-stream
        send(32'd100, 1'b0);
        send(32'd5, 1'b1);
        rd("pre_rst_mem0", 0, 32'd105);
        check("pre_rst_wptr", 32'(wptr), 32'd1);
        send(32'd7, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_M2done", 32'(M2done), 32'd0);
        check("arst_ready", 32'(prod_ready), 32'd0);
        check("arst_wptr", 32'(wptr), 32'd0);
        for (int a = 0; a < 16; a++) begin
            raddr = 4'(a);
            #0.1;
            check("arst_rd", regf_data, 32'd0);
        end
        #1;
        rst = 1'b0;
        cyc();

        // Wrap and sign
        pulse_start();
        send(32'h7FFF_FFFF, 1'b0);
        send(32'h0000_0001, 1'b1);
        send(32'hFFFF_FFFB, 1'b0);
        send(32'hFFFF_FFF9, 1'b1);
        rd("wrap_mem0", 0, 32'h8000_0000);
        rd("sign_mem1", 1, 32'hFFFF_FFF4);
        check("wrap_wptr", 32'(wptr), 32'd2);

        // Back-to-back singles with gaps (junk last flag in gaps)
        pulse_start();
        for (int k = 0; k < 10; k++) begin
            if (k % 3 == 1) begin
                prod_data = 32'hDEAD_0000;
                prod_last = 1'b1;
                cyc();
                prod_last = 1'b0;
                check("gap_wptr", 32'(wptr), 32'(k));
            end
            send(vals[k], 1'b1);
        end
        check("b2b_done", 32'(M2done), 32'd1);
        for (int k = 0; k < 10; k++) rd("b2b_mem", k, vals[k]);
        for (int a = 10; a < 16; a++) rd("oob_rd", a, 32'd0);

        // Abort after 4 commits
        pulse_start();
        for (int k = 0; k < 4; k++) send(nv[k], 1'b1);
        check("abort_pre_wptr", 32'(wptr), 32'd4);
        start      = 1'b1;
        prod_valid = 1'b1;
        prod_data  = 32'h0000_DEAD;
        prod_last  = 1'b1;
        cyc();
        start      = 1'b0;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        check("abort_wptr", 32'(wptr), 32'd0);
        check("abort_ready", 32'(prod_ready), 32'd1);
        for (int k = 0; k < 4; k++) rd("abort_new", k, nv[k]);
        for (int k = 4; k < 10; k++) rd("abort_old", k, vals[k]);

        // Refill: same-cycle read shows old value, then 10 new commits
        prod_valid = 1'b1;
        prod_data  = rv[0];
        prod_last  = 1'b1;
        raddr      = 4'd0;
        #1;
        check("same_cycle_old", regf_data, nv[0]);
        cyc();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        for (int k = 1; k < 10; k++) begin
            check("refill_not_done", 32'(M2done), 32'd0);
            send(rv[k], 1'b1);
        end
        check("refill_done", 32'(M2done), 32'd1);
        for (int k = 0; k < 10; k++) rd("refill_mem", k, rv[k]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
